// File: rtl/expr_check_arbiter.sv
// Round-robin arbiter sharing one expression recognizer among N byte-stream requesters.
// One requester owns the recognizer for a whole string; a verdict pulse follows its last byte.
module expr_check_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned LEN_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N-1:0]     req_valid,
    input  logic [8*N-1:0]   req_data,
    input  logic [N-1:0]     req_last,
    output logic [N-1:0]     req_ready,
    output logic             busy,
    output logic             res_valid,
    output logic [2:0]       res_id,
    output logic             res_ok,
    output logic [LEN_W-1:0] res_len,
    output logic [CNT_W-1:0] acc_cnt
);

    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRecv, StResp} st_e;
    typedef enum logic [2:0] {RecS0, RecS1, RecS2, RecP1, RecP2, RecP3, RecErr} rec_e;

    st_e              st_q, st_d;
    rec_e             rec_q, rec_d;
    logic [GW-1:0]    gnt_q, gnt_d;
    logic [GW-1:0]    last_gnt_q, last_gnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [2:0]       res_id_q, res_id_d;
    logic             res_ok_q, res_ok_d;
    logic [LEN_W-1:0] res_len_q, res_len_d;
    logic [CNT_W-1:0] acc_q, acc_d;

    logic [GW-1:0]    pick;
    logic             found;
    logic             hs;
    logic [7:0]       cur_byte;

    function automatic rec_e rec_step(input rec_e s, input logic [7:0] c);
        logic dig, op;
        dig = (c >= 8'h30) && (c <= 8'h39);
        op  = (c == 8'h2b) || (c == 8'h2a);
        rec_step = RecErr;
        case (s)
            RecS0, RecS2: begin
                if (dig)             rec_step = RecS1;
                else if (c == 8'h28) rec_step = RecP1;
            end
            RecS1:        if (op) rec_step = RecS2;
            RecP1, RecP3: if (dig) rec_step = RecP2;
            RecP2: begin
                if (op)              rec_step = RecP3;
                else if (c == 8'h29) rec_step = RecS1;
            end
            default:      rec_step = RecErr;
        endcase
    endfunction

    // Scan from the requester after the last grant, wrapping mod N.
    always_comb begin
        pick  = last_gnt_q;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            int unsigned idx;
            idx = (32'(last_gnt_q) + k) % N;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    assign hs       = (st_q == StRecv) && req_valid[gnt_q];
    assign cur_byte = req_data[8*gnt_q +: 8];

    always_comb begin
        st_d       = st_q;
        rec_d      = rec_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        len_d      = len_q;
        res_id_d   = res_id_q;
        res_ok_d   = res_ok_q;
        res_len_d  = res_len_q;
        acc_d      = acc_q;
        req_ready  = '0;
        res_valid  = 1'b0;
        case (st_q)
            StIdle: begin
                if (found) begin
                    gnt_d = pick;
                    rec_d = RecS0;
                    len_d = '0;
                    st_d  = StRecv;
                end
            end
            StRecv: begin
                req_ready[gnt_q] = req_valid[gnt_q];
                if (hs) begin
                    rec_d = rec_step(rec_q, cur_byte);
                    if (len_q != '1) begin
                        len_d = len_q + 1'b1;
                    end
                    // A length that reaches the counter ceiling can no longer be reported exactly.
                    if (len_d == '1) begin
                        rec_d = RecErr;
                    end
                    if (req_last[gnt_q]) begin
                        st_d      = StResp;
                        res_id_d  = 3'(gnt_q);
                        res_len_d = len_d;
                        res_ok_d  = (rec_d == RecS1);
                    end
                end
            end
            StResp: begin
                res_valid = 1'b1;
                if (res_ok_q && (acc_q != '1)) begin
                    acc_d = acc_q + 1'b1;
                end
                last_gnt_d = gnt_q;
                st_d       = StIdle;
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            st_q       <= StIdle;
            rec_q      <= RecS0;
            gnt_q      <= '0;
            last_gnt_q <= GW'(N - 1);
            len_q      <= '0;
            res_id_q   <= '0;
            res_ok_q   <= 1'b0;
            res_len_q  <= '0;
            acc_q      <= '0;
        end else begin
            st_q       <= st_d;
            rec_q      <= rec_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            len_q      <= len_d;
            res_id_q   <= res_id_d;
            res_ok_q   <= res_ok_d;
            res_len_q  <= res_len_d;
            acc_q      <= acc_d;
        end
    end

    assign busy    = (st_q != StIdle);
    assign res_id  = res_id_q;
    assign res_ok  = res_ok_q;
    assign res_len = res_len_q;
    assign acc_cnt = acc_q;

endmodule

// File: tb/tb_expr_check_arbiter.sv
// Directed bench for expr_check_arbiter: grammar verdicts, round-robin order, stalls,
// mid-string reset and length saturation on a narrow-length instance.
module tb_expr_check_arbiter;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic        busy, res_valid, res_ok;
    logic [2:0]  res_id;
    logic [7:0]  res_len;
    logic [15:0] acc_cnt;

    logic [3:0]  b_valid, b_last, b_ready;
    logic [31:0] b_data;
    logic        b_busy, b_res_valid, b_res_ok;
    logic [2:0]  b_res_id;
    logic [2:0]  b_res_len;
    logic [15:0] b_acc;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int r3_cnt = 0;
    int b_nv = 0;
    int b_ok = 0;
    int b_len = 0;
    int vid[$];
    int vok[$];
    int vlen[$];
    int vcyc[$];

    always #5 clk = ~clk;

    expr_check_arbiter #(.N(4), .LEN_W(8), .CNT_W(16)) dut (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .busy(busy), .res_valid(res_valid),
        .res_id(res_id), .res_ok(res_ok), .res_len(res_len), .acc_cnt(acc_cnt)
    );

    expr_check_arbiter #(.N(4), .LEN_W(3), .CNT_W(16)) dut3 (
        .clk(clk), .clr(clr), .req_valid(b_valid), .req_data(b_data),
        .req_last(b_last), .req_ready(b_ready), .busy(b_busy), .res_valid(b_res_valid),
        .res_id(b_res_id), .res_ok(b_res_ok), .res_len(b_res_len), .acc_cnt(b_acc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sampling process: records every verdict with its cycle number.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (req_ready[3]) r3_cnt++;
            if (res_valid) begin
                vid.push_back(int'(res_id));
                vok.push_back(int'(res_ok));
                vlen.push_back(int'(res_len));
                vcyc.push_back(cyc);
            end
            if (b_res_valid) begin
                b_nv++;
                b_ok  = int'(b_res_ok);
                b_len = int'(b_res_len);
            end
        end
    end

    task automatic send_byte(input int id, input byte ch, input bit last);
        int b;
        b = 0;
        req_valid[id] = 1'b1;
        req_data[8*id +: 8] = ch;
        req_last[id] = last;
        #1;
        while (!req_ready[id] && b < 100) begin
            @(negedge clk);
            #1;
            b++;
        end
        if (b >= 100) check_eq("ready_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic send_str(input int id, input string s);
        for (int i = 0; i < s.len(); i++) send_byte(id, s[i], i == s.len() - 1);
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
    endtask

    task automatic send_b(input string s);
        int b;
        for (int i = 0; i < s.len(); i++) begin
            b = 0;
            b_valid[0] = 1'b1;
            b_data[7:0] = s[i];
            b_last[0] = (i == s.len() - 1);
            #1;
            while (!b_ready[0] && b < 100) begin
                @(negedge clk);
                #1;
                b++;
            end
            if (b >= 100) check_eq("b_ready_timeout", 0, 1);
            @(negedge clk);
        end
        b_valid[0] = 1'b0;
        b_last[0]  = 1'b0;
    endtask

    task automatic wait_v(input int n, input string tag);
        int b;
        b = 0;
        while (vid.size() < n && b < 200) begin
            @(negedge clk);
            #3;
            b++;
        end
        check_eq(tag, vid.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nv;
        int r3_before;
        clr = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0;
        b_valid = '0; b_last = '0; b_data = '0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_res_id", res_id, 0);
        check_eq("rst_res_ok", res_ok, 0);
        check_eq("rst_res_len", res_len, 0);
        check_eq("rst_acc", acc_cnt, 0);
        check_eq("rst_b_busy", b_busy, 0);
        @(negedge clk);
        clr = 1'b0;

        // Legal string with a parenthesised term.
        send_str(0, "1+(2*3)");
        wait_v(1, "t1_count");
        check_eq("t1_id", vid[0], 0);
        check_eq("t1_ok", vok[0], 1);
        check_eq("t1_len", vlen[0], 7);
        repeat (2) @(negedge clk);
        check_eq("t1_acc", acc_cnt, 1);

        // Illegal strings from requester 1.
        send_str(1, "1+");
        send_str(1, "(12)");
        send_str(1, "((1))");
        send_str(1, ")");
        wait_v(5, "t2_count");
        check_eq("t2_ok_a", vok[1], 0);
        check_eq("t2_len_a", vlen[1], 2);
        check_eq("t2_ok_b", vok[2], 0);
        check_eq("t2_len_b", vlen[2], 4);
        check_eq("t2_ok_c", vok[3], 0);
        check_eq("t2_len_c", vlen[3], 5);
        check_eq("t2_ok_d", vok[4], 0);
        check_eq("t2_len_d", vlen[4], 1);
        check_eq("t2_id_d", vid[4], 1);
        repeat (3) @(negedge clk);
        check_eq("t2_hold_id", res_id, 1);
        check_eq("t2_hold_len", res_len, 1);
        check_eq("t2_acc", acc_cnt, 1);

        // Reset, then all four requesters contend with one-byte strings.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        check_eq("t3_acc_clr", acc_cnt, 0);
        @(negedge clk);
        req_valid = 4'hf;
        req_last  = 4'hf;
        req_data  = {4{8'h35}};
        repeat (15) @(negedge clk);
        req_valid = '0;
        req_last  = '0;
        wait_v(10, "t3_count");
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("t3_id%0d", i), vid[5+i], i % 4);
            check_eq($sformatf("t3_ok%0d", i), vok[5+i], 1);
        end
        for (int i = 1; i < 5; i++) check_eq($sformatf("t3_gap%0d", i), vcyc[5+i] - vcyc[4+i], 3);
        repeat (2) @(negedge clk);
        check_eq("t3_acc", acc_cnt, 5);

        // Requester 2 stalls mid-string while requester 3 waits.
        @(negedge clk);
        r3_before = r3_cnt;
        req_valid[3] = 1'b1;
        req_data[31:24] = 8'h37;
        req_last[3] = 1'b1;
        send_byte(2, "9", 1'b0);
        send_byte(2, "*", 1'b0);
        req_valid[2] = 1'b0;
        for (int g = 0; g < 4; g++) begin
            #1;
            check_eq($sformatf("t4_gap_rdy%0d", g), req_ready, 0);
            @(negedge clk);
        end
        send_byte(2, "8", 1'b1);
        req_valid[2] = 1'b0;
        req_last[2]  = 1'b0;
        wait_v(11, "t4_count");
        check_eq("t4_id", vid[10], 2);
        check_eq("t4_ok", vok[10], 1);
        check_eq("t4_len", vlen[10], 3);
        check_eq("t4_r3_early", r3_cnt - r3_before, 0);
        send_byte(3, "7", 1'b1);
        req_valid[3] = 1'b0;
        req_last[3]  = 1'b0;
        wait_v(12, "t4_count3");
        check_eq("t4_id3", vid[11], 3);
        check_eq("t4_ok3", vok[11], 1);
        repeat (2) @(negedge clk);
        check_eq("t4_acc", acc_cnt, 7);

        // Reset in the middle of a string abandons it.
        send_byte(1, "1", 1'b0);
        send_byte(1, "+", 1'b0);
        nv = vid.size();
        req_valid[1] = 1'b0;
        clr = 1'b1;
        req_valid[0] = 1'b1;
        req_data[7:0] = 8'h35;
        req_last[0] = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        check_eq("t5_busy", busy, 0);
        check_eq("t5_res_valid", res_valid, 0);
        check_eq("t5_acc", acc_cnt, 0);
        check_eq("t5_ready", req_ready, 0);
        @(negedge clk);
        send_byte(0, "5", 1'b1);
        req_valid[0] = 1'b0;
        req_last[0]  = 1'b0;
        wait_v(nv + 1, "t5_count");
        check_eq("t5_id", vid[nv], 0);
        check_eq("t5_ok", vok[nv], 1);
        repeat (2) @(negedge clk);
        check_eq("t5_acc_after", acc_cnt, 1);

        // Narrow length counter saturates and forces a reject.
        @(negedge clk);
        send_b("1+1+1+1+");
        repeat (4) @(negedge clk);
        check_eq("t6_count", b_nv, 1);
        check_eq("t6_ok", b_ok, 0);
        check_eq("t6_len", b_len, 7);
        check_eq("t6_acc", b_acc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
